// File: rtl/synchronous_fifo_ext.sv
`default_nettype none
// ============================================================================
//  Module      : synchronous_fifo_ext
//  Description : Single-clock FIFO with occupancy count, programmable
//                almost-full/almost-empty thresholds, one-cycle overflow and
//                underflow pulses, and selectable standard or
//                first-word-fall-through read mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module synchronous_fifo_ext #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    logic rd_acc;
    logic wr_acc;

    // Flags come straight from the registered count, so they are glitch-free.
    assign empty        = (count_q == '0);
    assign full         = (count_q == C_DEPTH);
    assign almost_full  = (count_q >= C_AFULL);
    assign almost_empty = (count_q <= C_AEMPTY);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write alongside a read; an empty FIFO never passes data straight through.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    // Next-state for pointers, occupancy and error pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = w_en && !wr_acc;
        udf_d    = r_en && !rd_acc;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array: not cleared by reset, but writes are blocked on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero when nothing is stored.
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            // Registered read port: updates only on an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem_q[rd_ptr_q];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_synchronous_fifo_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_synchronous_fifo_ext
//  Description : Directed self-checking bench for synchronous_fifo_ext in
//                standard and first-word-fall-through modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_synchronous_fifo_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // standard-mode instance
    logic       w_en = 1'b0, r_en = 1'b0;
    logic [7:0] din  = '0;
    logic [7:0] dout;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [3:0] cnt;

    // fall-through instance
    logic       f_w_en = 1'b0, f_r_en = 1'b0;
    logic [7:0] f_din  = '0;
    logic [7:0] f_dout;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [3:0] f_cnt;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] sb [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    synchronous_fifo_ext #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6),
                           .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(din),
        .data_out(dout), .full(full), .empty(empty), .almost_full(afull),
        .almost_empty(aempty), .count(cnt), .overflow(ovf), .underflow(udf)
    );

    synchronous_fifo_ext #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6),
                           .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(f_w_en), .r_en(f_r_en), .data_in(f_din),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs and samples sit 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        w_en = 1'b1; din = d; tick(); w_en = 1'b0;
    endtask

    task automatic rd();
        r_en = 1'b1; tick(); r_en = 1'b0;
    endtask

    initial begin
        // ---- 1: reset and fill ----
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_empty",  {31'd0, empty},  1);
        chk("rst_count",  {28'd0, cnt},    0);
        chk("rst_dout",   {24'd0, dout},   0);
        chk("rst_aempty", {31'd0, aempty}, 1);
        chk("rst_full",   {31'd0, full},   0);
        chk("rst_afull",  {31'd0, afull},  0);
        chk("rst_ovf",    {31'd0, ovf},    0);
        chk("rst_udf",    {31'd0, udf},    0);
        chk("rst_f_dout", {24'd0, f_dout}, 0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr(8'(i));
            chk("fill_count", {28'd0, cnt}, i);
            if (i == 3) chk("aempty_off_3", {31'd0, aempty}, 0);
            if (i == 5) chk("afull_off_5",  {31'd0, afull},  0);
            if (i == 6) chk("afull_on_6",   {31'd0, afull},  1);
            if (i == 7) chk("full_off_7",   {31'd0, full},   0);
        end
        chk("full_on_8", {31'd0, full}, 1);
        wr(8'h09);
        chk("ovf_pulse",     {31'd0, ovf}, 1);
        chk("ovf_count",     {28'd0, cnt}, 8);
        tick();
        chk("ovf_cleared",   {31'd0, ovf}, 0);

        // ---- 2: drain in standard mode ----
        for (int i = 1; i <= 8; i++) begin
            rd();
            chk("drain_data",  {24'd0, dout}, i);
            chk("drain_count", {28'd0, cnt},  8 - i);
            if (i == 5) chk("aempty_off_c3", {31'd0, aempty}, 0);
            if (i == 6) chk("aempty_on_c2",  {31'd0, aempty}, 1);
            if (i == 7) chk("empty_off_c1",  {31'd0, empty},  0);
        end
        chk("drain_empty", {31'd0, empty}, 1);
        rd();
        chk("udf_pulse", {31'd0, udf},  1);
        chk("udf_hold",  {24'd0, dout}, 8'h08);
        tick();
        chk("udf_cleared", {31'd0, udf}, 0);

        // ---- 3: simultaneous read/write at the boundaries ----
        for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
        w_en = 1'b1; r_en = 1'b1; din = 8'hAA;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("rw_full_count", {28'd0, cnt},  8);
        chk("rw_full_full",  {31'd0, full}, 1);
        chk("rw_full_ovf",   {31'd0, ovf},  0);
        chk("rw_full_data",  {24'd0, dout}, 8'h10);
        for (int i = 1; i <= 8; i++) begin
            rd();
            exp_d = (i == 8) ? 8'hAA : 8'h10 + 8'(i);
            chk("rw_full_order", {24'd0, dout}, {24'd0, exp_d});
        end
        chk("rw_empty_pre", {31'd0, empty}, 1);
        w_en = 1'b1; r_en = 1'b1; din = 8'h55;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        chk("rw_empty_count", {28'd0, cnt},  1);
        chk("rw_empty_udf",   {31'd0, udf},  1);
        chk("rw_empty_hold",  {24'd0, dout}, 8'hAA);
        rd();
        chk("rw_empty_data",  {24'd0, dout}, 8'h55);
        chk("rw_empty_after", {31'd0, empty}, 1);

        // ---- 4: wrap-around with scoreboard ----
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'($urandom);
            sb.push_back(exp_d);
            wr(exp_d);
            chk("wrap_err", {30'd0, ovf, udf}, 0);
        end
        for (int i = 0; i < 20; i++) begin
            if (i < 17) begin
                exp_d = 8'($urandom);
                sb.push_back(exp_d);
                wr(exp_d);
                chk("wrap_err", {30'd0, ovf, udf}, 0);
            end
            rd();
            exp_d = sb.pop_front();
            chk("wrap_data",  {24'd0, dout}, {24'd0, exp_d});
            chk("wrap_count", {28'd0, cnt},  sb.size());
            chk("wrap_err",   {30'd0, ovf, udf}, 0);
        end
        chk("wrap_empty", {31'd0, empty}, 1);

        // ---- 5: first-word-fall-through ----
        chk("fwft_empty0", {24'd0, f_dout}, 0);
        f_w_en = 1'b1; f_din = 8'h3C; tick(); f_w_en = 1'b0;
        chk("fwft_first",  {24'd0, f_dout}, 8'h3C);
        tick();
        chk("fwft_hold",   {24'd0, f_dout}, 8'h3C);
        f_w_en = 1'b1; f_din = 8'h4D; tick(); f_w_en = 1'b0;
        chk("fwft_head",   {24'd0, f_dout}, 8'h3C);
        f_r_en = 1'b1; tick(); f_r_en = 1'b0;
        chk("fwft_pop1",   {24'd0, f_dout}, 8'h4D);
        chk("fwft_cnt1",   {28'd0, f_cnt},  1);
        f_r_en = 1'b1; tick(); f_r_en = 1'b0;
        chk("fwft_empty",  {31'd0, f_empty}, 1);
        chk("fwft_zero",   {24'd0, f_dout},  0);
        chk("fwft_no_udf", {31'd0, f_udf},   0);

        // ---- 6: mid-operation reset ----
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
        rd();
        chk("pre_rst_data", {24'd0, dout}, 8'h60);
        wr(8'h65);
        chk("pre_rst_count", {28'd0, cnt}, 5);
        rst = 1'b1; w_en = 1'b1; din = 8'h99;
        tick();
        rst = 1'b0; w_en = 1'b0;
        chk("mrst_count", {28'd0, cnt},   0);
        chk("mrst_empty", {31'd0, empty}, 1);
        chk("mrst_dout",  {24'd0, dout},  0);
        chk("mrst_ovf",   {31'd0, ovf},   0);
        wr(8'h70);
        wr(8'h71);
        chk("post_count", {28'd0, cnt}, 2);
        rd();
        chk("post_data0", {24'd0, dout}, 8'h70);
        rd();
        chk("post_data1", {24'd0, dout}, 8'h71);
        chk("post_empty", {31'd0, empty}, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
